// File: rtl/maquina_estados_pet_if.sv
// maquina_estados_pet_if: buttons, attribute levels and FSM outputs of the virtual pet
interface maquina_estados_pet_if;
  logic       btn_start;
  logic       btn_dormir;
  logic       btn_comer;
  logic       btn_aula;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic [4:0] estado;
  logic       reiniciar;
  logic       alerta;
  modport master (
    output btn_start, btn_dormir, btn_comer, btn_aula, fome, felicidade, sono,
    input  estado, reiniciar, alerta
  );
  modport slave (
    input  btn_start, btn_dormir, btn_comer, btn_aula, fome, felicidade, sono,
    output estado, reiniciar, alerta
  );
endinterface

// File: rtl/maquina_estados_pet.sv
// maquina_estados_pet: behaviour FSM of the virtual pet with death, restart and low-attribute warning
module maquina_estados_pet #(
  parameter logic [7:0] MAX_ATRIBUTO  = 8'd100,
  parameter logic [7:0] LIMIAR_ALERTA = 8'd20
) (
  input logic                   clk,
  input logic                   rst_n,
  maquina_estados_pet_if.slave  bus
);
  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } estado_t;
  estado_t    r_estado;
  logic       r_reiniciar;
  logic       r_alerta;
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_s2_d;
  logic [3:0] w_btn;
  logic [3:0] w_ev;
  logic       w_ev_start;
  logic       w_ev_dormir;
  logic       w_ev_comer;
  logic       w_ev_aula;
  logic       w_zero;
  logic       w_baixo;
  assign w_btn       = {bus.btn_aula, bus.btn_comer, bus.btn_dormir, bus.btn_start};
  assign w_ev        = r_s2 & ~r_s2_d;
  assign w_ev_start  = w_ev[0];
  assign w_ev_dormir = w_ev[1];
  assign w_ev_comer  = w_ev[2];
  assign w_ev_aula   = w_ev[3];
  assign w_zero      = (bus.fome == 8'd0) | (bus.felicidade == 8'd0) | (bus.sono == 8'd0);
  assign w_baixo     = (bus.fome < LIMIAR_ALERTA) | (bus.felicidade < LIMIAR_ALERTA) |
                       (bus.sono < LIMIAR_ALERTA);
  assign bus.estado    = r_estado;
  assign bus.reiniciar = r_reiniciar;
  assign bus.alerta    = r_alerta;
  // Button synchronizers plus a delay stage so each press yields a single rising-edge event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s2_d <= '0;
    end else begin
      r_s1   <= w_btn;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end
  // State transitions with death overriding buttons, buttons overriding saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= INTRO;
      r_reiniciar <= 1'b0;
      r_alerta    <= 1'b0;
    end else begin
      r_reiniciar <= (r_estado == MORTO) && w_ev_start;
      r_alerta    <= (r_estado != INTRO) && (r_estado != MORTO) && w_baixo;
      case (r_estado)
        INTRO:      r_estado <= w_ev_start ? IDLE : INTRO;
        IDLE:       r_estado <= w_zero      ? MORTO    :
                                w_ev_dormir ? DORMINDO :
                                w_ev_comer  ? COMENDO  :
                                w_ev_aula   ? DANDO_AULA : IDLE;
        DORMINDO:   r_estado <= w_zero      ? MORTO      :
                                w_ev_dormir ? IDLE       :
                                w_ev_comer  ? COMENDO    :
                                w_ev_aula   ? DANDO_AULA :
                                (bus.sono >= MAX_ATRIBUTO) ? IDLE : DORMINDO;
        COMENDO:    r_estado <= w_zero      ? MORTO      :
                                w_ev_comer  ? IDLE       :
                                w_ev_dormir ? DORMINDO   :
                                w_ev_aula   ? DANDO_AULA :
                                (bus.fome >= MAX_ATRIBUTO) ? IDLE : COMENDO;
        DANDO_AULA: r_estado <= w_zero      ? MORTO    :
                                w_ev_aula   ? IDLE     :
                                w_ev_dormir ? DORMINDO :
                                w_ev_comer  ? COMENDO  :
                                (bus.felicidade >= MAX_ATRIBUTO) ? IDLE : DANDO_AULA;
        MORTO:      r_estado <= w_ev_start ? INTRO : MORTO;
        default:    r_estado <= INTRO;
      endcase
    end
  end
endmodule

// File: tb/tb_maquina_estados_pet.sv
// tb_maquina_estados_pet: directed vectors checked through an expectation queue and a negedge monitor
module tb_maquina_estados_pet;
  localparam logic [4:0] INTRO = 5'b00000, IDLE = 5'b00001, DORMINDO = 5'b00010,
                         COMENDO = 5'b00100, DANDO_AULA = 5'b01000, MORTO = 5'b10000;
  localparam logic [3:0] B_START = 4'b0001, B_DORMIR = 4'b0010, B_COMER = 4'b0100, B_AULA = 4'b1000;
  typedef struct {
    string      nm;
    int         due;
    logic [4:0] e;
    logic       r;
    logic       a;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  maquina_estados_pet_if bus();
  maquina_estados_pet dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic push(input string nm, input int off, input logic [4:0] e, input logic r, input logic a);
    exp_t x;
    x.nm = nm; x.due = cyc + off; x.e = e; x.r = r; x.a = a;
    q.push_back(x);
  endtask
  task automatic set_btn(input logic [3:0] m);
    {bus.btn_aula, bus.btn_comer, bus.btn_dormir, bus.btn_start} = m;
  endtask
  task automatic press(input logic [3:0] m);
    set_btn(m);
    step(1);
    set_btn(4'b0000);
  endtask
  initial begin
    exp_t h;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        h = q.pop_front();
        tests++;
        if (h.due < cyc) begin
          fails++;
          $display("FAIL %s: check missed, due cycle %0d, now %0d", h.nm, h.due, cyc);
        end else if ({bus.estado, bus.reiniciar, bus.alerta} !== {h.e, h.r, h.a}) begin
          fails++;
          $display("FAIL %s: estado=%b reiniciar=%b alerta=%b, expected estado=%b reiniciar=%b alerta=%b",
                   h.nm, bus.estado, bus.reiniciar, bus.alerta, h.e, h.r, h.a);
        end
      end
    end
  end
  initial begin
    set_btn(4'b0000);
    bus.fome = 8'd80; bus.felicidade = 8'd70; bus.sono = 8'd50;
    step(1);
    push("reset", 0, INTRO, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    push("start_early", 2, INTRO, 1'b0, 1'b0);
    push("start", 3, IDLE, 1'b0, 1'b0);
    press(B_START);
    step(3);
    push("simul", 3, COMENDO, 1'b0, 1'b0);
    press(B_COMER | B_AULA);
    step(3);
    push("toggle", 3, IDLE, 1'b0, 1'b0);
    press(B_COMER);
    step(3);
    push("hold", 3, DORMINDO, 1'b0, 1'b0);
    push("hold_end", 50, DORMINDO, 1'b0, 1'b0);
    set_btn(B_DORMIR);
    step(50);
    set_btn(4'b0000);
    step(3);
    push("to_aula", 3, DANDO_AULA, 1'b0, 1'b0);
    press(B_AULA);
    step(3);
    bus.felicidade = 8'd93;
    push("sat93", 1, DANDO_AULA, 1'b0, 1'b0);
    step(2);
    bus.felicidade = 8'd100;
    push("sat", 1, IDLE, 1'b0, 1'b0);
    step(3);
    bus.felicidade = 8'd70;
    push("aula2", 3, DANDO_AULA, 1'b0, 1'b0);
    press(B_AULA);
    step(3);
    push("sat_btn", 3, DORMINDO, 1'b0, 1'b0);
    press(B_DORMIR);
    step(1);
    bus.felicidade = 8'd100;
    step(3);
    bus.felicidade = 8'd70;
    push("to_comer", 3, COMENDO, 1'b0, 1'b0);
    press(B_COMER);
    step(3);
    push("death", 3, MORTO, 1'b0, 1'b1);
    push("death_alerta", 4, MORTO, 1'b0, 1'b0);
    press(B_AULA);
    step(1);
    bus.sono = 8'd0;
    step(3);
    press(B_DORMIR);
    step(3);
    push("dead_stay", 3, MORTO, 1'b0, 1'b0);
    press(B_COMER);
    step(3);
    push("restart", 3, INTRO, 1'b1, 1'b0);
    push("restart_end", 4, INTRO, 1'b0, 1'b0);
    press(B_START);
    step(3);
    bus.sono = 8'd50;
    step(1);
    push("restart_idle", 3, IDLE, 1'b0, 1'b0);
    push("no_death", 6, IDLE, 1'b0, 1'b0);
    press(B_START);
    step(6);
    bus.fome = 8'd19;
    push("alerta_pre", 0, IDLE, 1'b0, 1'b0);
    push("alerta_on", 1, IDLE, 1'b0, 1'b1);
    step(2);
    bus.fome = 8'd20;
    push("alerta_off", 1, IDLE, 1'b0, 1'b0);
    step(2);
    bus.fome = 8'd80;
    push("to_dorm", 3, DORMINDO, 1'b0, 1'b0);
    press(B_DORMIR);
    step(3);
    rst_n = 1'b0;
    push("async_rst", 0, INTRO, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    bus.fome = 8'd19;
    push("intro_alerta", 2, INTRO, 1'b0, 1'b0);
    step(3);
    bus.fome = 8'd80;
    step(2);
    while (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d", q[0].nm, q[0].due, cyc);
      void'(q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
